mem_line_xfer: RTL and testbench

MEM_LINE_XFER -- requirements
Module: mem_line_xfer

---
 rtl/mem_line_xfer.sv | 133 +++++++++++++
 tb/tb_mem_line_xfer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_xfer.sv
// rtl/mem_line_xfer.sv - line-granular read/write sequencer for a 32-bit word memory
//
// Moves one line of N = 2**LINE_LEN 32-bit words between a wide line bus and
// a single-ported synchronous memory, one word per clock.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid       transfer request, taken only while ready is high
//   req_we          1 = write wr_line to memory, 0 = read line into rd_line
//   req_line        line address (word address without the in-line offset)
//   wr_line         write data, word k at bits [32k+31:32k]
//   ready           high while idle
//   done            one-cycle pulse in the first idle cycle after a transfer
//   rd_line         read data, same packing as wr_line, held until next read
//   mem_addr        memory word address
//   mem_wr_req      memory write strobe
//   mem_wr_data     memory write data
//   mem_rd_data     memory read data, valid one cycle after mem_addr
module mem_line_xfer #(
  parameter int ADDR_LEN = 11,
  parameter int LINE_LEN = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  input  logic                             req_we,
  input  logic [ADDR_LEN-LINE_LEN-1:0]     req_line,
  input  logic [32*(2**LINE_LEN)-1:0]      wr_line,
  output logic                             ready,
  output logic                             done,
  output logic [32*(2**LINE_LEN)-1:0]      rd_line,
  output logic [ADDR_LEN-1:0]              mem_addr,
  output logic                             mem_wr_req,
  output logic [31:0]                      mem_wr_data,
  input  logic [31:0]                      mem_rd_data
);

  localparam int N  = 2**LINE_LEN;
  localparam int LW = 32*N;

  typedef enum logic [1:0] {IDLE, READ, READ_TAIL, WRITE} state_t;

  state_t                        state;
  logic [LINE_LEN-1:0]           cnt;
  logic                          we_q;
  logic [ADDR_LEN-LINE_LEN-1:0]  line_q;
  logic [LW-1:0]                 wr_q;

  logic [LINE_LEN-1:0]           cnt_nx;
  logic [LINE_LEN-1:0]           cnt_pv;
  logic                          cnt_last;

  assign cnt_nx   = cnt + 1'b1;
  assign cnt_pv   = cnt - 1'b1;
  assign cnt_last = (cnt == '1);

  // state is a register, so ready is a clean decode of registered state
  assign ready = (state == IDLE);

  // mem_addr and mem_wr_data are loaded one edge ahead with the value the
  // next cycle needs, so they equal {line_q, cnt} and word cnt while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      line_q      <= '0;
      wr_q        <= '0;
      done        <= 1'b0;
      rd_line     <= '0;
      mem_addr    <= '0;
      mem_wr_req  <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            line_q   <= req_line;
            cnt      <= '0;
            mem_addr <= {req_line, {LINE_LEN{1'b0}}};
            if (req_we) begin
              wr_q        <= wr_line;
              mem_wr_req  <= 1'b1;
              mem_wr_data <= wr_line[31:0];
              state       <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          // data for the address of the previous cycle arrives now
          if (cnt != '0)
            rd_line[{cnt_pv, 5'b0} +: 32] <= mem_rd_data;
          cnt <= cnt_nx;
          if (cnt_last) begin
            mem_addr <= '0;
            state    <= READ_TAIL;
          end else begin
            mem_addr <= {line_q, cnt_nx};
          end
        end
        READ_TAIL: begin
          rd_line[LW-1 -: 32] <= mem_rd_data;
          cnt   <= '0;
          done  <= 1'b1;
          state <= IDLE;
        end
        WRITE: begin
          cnt <= cnt_nx;
          if (cnt_last) begin
            mem_addr    <= '0;
            mem_wr_req  <= 1'b0;
            mem_wr_data <= '0;
            done        <= 1'b1;
            state       <= IDLE;
          end else begin
            mem_addr    <= {line_q, cnt_nx};
            mem_wr_data <= wr_q[{cnt_nx, 5'b0} +: 32];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // direction is carried by the state; the latched copy is kept for debug visibility
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_mem_line_xfer.sv
// tb/tb_mem_line_xfer.sv - self-checking bench for mem_line_xfer
module tb_mem_line_xfer;

  localparam int AL = 11;
  localparam int LL = 3;
  localparam int N  = 8;
  localparam int LW = 32*N;
  localparam int NW = 2048;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_we = 1'b0;
  logic [AL-LL-1:0] req_line = '0;
  logic [LW-1:0]  wr_line = '0;
  logic           ready;
  logic           done;
  logic [LW-1:0]  rd_line;
  logic [AL-1:0]  mem_addr;
  logic           mem_wr_req;
  logic [31:0]    mem_wr_data;
  logic [31:0]    mem_rd_data = '0;

  mem_line_xfer #(.ADDR_LEN(AL), .LINE_LEN(LL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_line(req_line), .wr_line(wr_line), .ready(ready), .done(done),
    .rd_line(rd_line), .mem_addr(mem_addr), .mem_wr_req(mem_wr_req),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // memory attached to the DUT: registered read, write on strobe
  logic [31:0] mem [NW];
  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_req) mem[mem_addr] <= mem_wr_data;
  end

  // reference contents and expected read line
  logic [31:0]   ref_mem [NW];
  logic [LW-1:0] last_rd;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] ref_line(input int line);
    logic [LW-1:0] r;
    for (int k = 0; k < N; k++) r[k*32 +: 32] = ref_mem[line*N + k];
    return r;
  endfunction

  function automatic logic [LW-1:0] seq_data(input int base);
    logic [LW-1:0] r;
    for (int k = 0; k < N; k++) r[k*32 +: 32] = 32'(base + k);
    return r;
  endfunction

  // One transfer from IDLE; poke > 0 pulses req_valid during that busy cycle.
  task automatic xfer(input logic we, input int line, input logic [LW-1:0] data, input int poke);
    int lat;
    logic [31:0] w;
    lat = we ? N + 1 : N + 2;
    @(negedge clk);
    chk("acc_ready", LW'(ready), LW'(1));
    req_valid = 1'b1;
    req_we    = we;
    req_line  = (AL-LL)'(line);
    wr_line   = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wr_line   = '0;
    for (int c = 1; c <= lat; c++) begin
      if (poke > 0 && c == poke) begin
        req_valid = 1'b1;
        req_we    = $urandom_range(0, 1);
        req_line  = (AL-LL)'($urandom);
      end
      if (poke > 0 && c == poke + 1) req_valid = 1'b0;
      if (c < lat) begin
        chk("busy_done", LW'(done), LW'(0));
        chk("busy_ready", LW'(ready), LW'(0));
      end
      if (c <= N) begin
        w = data[(c-1)*32 +: 32];
        chk("addr", LW'(mem_addr), LW'(line*N + c - 1));
        chk("wr_req", LW'(mem_wr_req), LW'(we));
        if (we) chk("wr_data", LW'(mem_wr_data), LW'(w));
      end else if (c < lat) begin
        chk("tail_wr_req", LW'(mem_wr_req), LW'(0));
      end
      if (c < lat) begin
        @(posedge clk); #1;
      end
    end
    chk("done", LW'(done), LW'(1));
    chk("done_ready", LW'(ready), LW'(1));
    chk("idle_addr", LW'(mem_addr), LW'(0));
    chk("idle_wr_req", LW'(mem_wr_req), LW'(0));
    if (we) begin
      for (int k = 0; k < N; k++) ref_mem[line*N + k] = data[k*32 +: 32];
    end else begin
      last_rd = ref_line(line);
    end
    chk(we ? "rd_line_hold" : "rd_line", rd_line, last_rd);
  endtask

  initial begin
    int d1, d2, dn;
    logic [LW-1:0] dat;
    for (int i = 0; i < NW; i++) begin
      mem[i]     = 32'(32'h100 + i);
      ref_mem[i] = 32'(32'h100 + i);
    end
    last_rd = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", LW'(ready), LW'(1));
    chk("rst_done", LW'(done), LW'(0));
    chk("rst_rd_line", rd_line, '0);
    chk("rst_addr", LW'(mem_addr), LW'(0));
    chk("rst_wr_req", LW'(mem_wr_req), LW'(0));
    chk("rst_wr_data", LW'(mem_wr_data), LW'(0));
    @(negedge clk); rst = 1'b0;

    xfer(1'b0, 0, '0, 0);
    xfer(1'b1, 5, seq_data(32'hA0), 0);
    xfer(1'b0, 5, '0, 0);
    chk("line5_readback", rd_line, seq_data(32'hA0));

    // stray request in the 3rd READ cycle must be dropped
    xfer(1'b0, 3, '0, 3);
    @(posedge clk); #1;
    chk("poke_no_2nd_done", LW'(done), LW'(0));
    chk("poke_still_idle", LW'(ready), LW'(1));

    xfer(1'b0, 255, '0, 0);

    // reset in the middle of the 4th write cycle of line 2
    dat = seq_data(32'hB0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_line = 8'd2; wr_line = dat;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_addr", LW'(mem_addr), LW'(19));
    #2 rst = 1'b1;
    #1;
    chk("arst_wr_req", LW'(mem_wr_req), LW'(0));
    chk("arst_ready", LW'(ready), LW'(1));
    chk("arst_addr", LW'(mem_addr), LW'(0));
    chk("arst_rd_line", rd_line, '0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) ref_mem[16 + k] = dat[k*32 +: 32];
    last_rd = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk("arst_no_done", LW'(done), LW'(0));
    end
    for (int a = 16; a < 24; a++) chk($sformatf("arst_mem%0d", a), LW'(mem[a]), LW'(ref_mem[a]));

    // req_valid held high: read line 1 then write line 1 back to back
    dat = seq_data(32'hC0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_line = 8'd1; wr_line = dat;
    @(posedge clk); #1;
    req_we = 1'b1;
    d1 = -1; d2 = -1; dn = 0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 11) req_valid = 1'b0;
      if (done) begin
        dn++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
      if (c == N + 2) chk("b2b_rd_line", rd_line, ref_line(1));
      @(posedge clk); #1;
    end
    chk("b2b_done_count", LW'(dn), LW'(2));
    chk("b2b_done1", LW'(d1), LW'(N + 2));
    chk("b2b_done2", LW'(d2), LW'(2*N + 3));
    last_rd = ref_line(1);
    for (int k = 0; k < N; k++) ref_mem[N + k] = dat[k*32 +: 32];
    xfer(1'b0, 1, '0, 0);

    // random traffic against the reference contents
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < N; k++) dat[k*32 +: 32] = $urandom;
      xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), dat, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
